// File: rtl/whack_pkg.sv
// -----------------------------------------------------------------------------
// whack_pkg
// Shared types and helpers for the reaction-game controller.
//   game_state_t : top-level game FSM states (IDLE/PLAY/WIN/LOSE)
//   ch_state_t   : per-channel lamp FSM states (CH_OFF/CH_ON)
//   TIME_W       : width of every phase counter and of the elapsed counter
//   sat_clamp    : clamps a signed value into the unsigned range [0, 2^width-1]
// -----------------------------------------------------------------------------
package whack_pkg;

  localparam int TIME_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } game_state_t;

  typedef enum logic {
    CH_OFF = 1'b0,
    CH_ON  = 1'b1
  } ch_state_t;

  // Saturate a signed quantity into an unsigned field of 'width' bits.
  // Works on a 64-bit carrier so one helper serves any score width up to 58.
  function automatic logic [63:0] sat_clamp(input logic signed [63:0] val,
                                            input int                 width);
    logic signed [63:0] max_val;
    max_val = (64'sd1 <<< width) - 64'sd1;
    if (val < 64'sd0) begin
      return 64'd0;
    end
    if (val > max_val) begin
      return $unsigned(max_val);
    end
    return $unsigned(val);
  endfunction

endpackage

// File: rtl/whack_channel.sv
// -----------------------------------------------------------------------------
// whack_channel
// One lamp/button channel of the reaction game.
//   clk, reset : system clock, synchronous active-high reset
//   btn_n      : raw active-low button, asynchronous to clk
//   play       : game is in PLAY; channel FSM and pulses are enabled
//   restart    : game leaves PLAY on this edge; force OFF with counter 0
//   lamp       : 1 while the channel is in its lit phase
//   start      : press seen outside PLAY (only when START_EN), starts a game
//   hit        : press while lit (one-cycle pulse, combinational)
//   miss       : lit phase expired unpressed (only when MISS_EN)
//   wrong      : press while dark (only when WRONG_EN)
// -----------------------------------------------------------------------------
module whack_channel
  import whack_pkg::*;
#(
  parameter logic [TIME_W-1:0] ON_TIME  = TIME_W'(1),
  parameter logic [TIME_W-1:0] OFF_TIME = TIME_W'(1),
  parameter bit                MISS_EN  = 1'b0,
  parameter bit                WRONG_EN = 1'b0,
  parameter bit                START_EN = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic play,
  input  logic restart,
  output logic lamp,
  output logic start,
  output logic hit,
  output logic miss,
  output logic wrong
);

  localparam logic [TIME_W-1:0] ON_LAST  = ON_TIME - 1'b1;
  localparam logic [TIME_W-1:0] OFF_LAST = OFF_TIME - 1'b1;

  ch_state_t         state_reg;
  logic [TIME_W-1:0] cnt_reg;
  logic              sync_a_reg;
  logic              sync_b_reg;
  logic              sync_c_reg;
  logic              press;
  logic              is_on;
  logic              on_done;
  logic              off_done;

  // sync_a/sync_b form the synchroniser; sync_c holds the previous
  // synchronised value so a falling edge yields a one-cycle press.
  assign press    = sync_c_reg & ~sync_b_reg;
  assign is_on    = (state_reg == CH_ON);
  assign on_done  = (cnt_reg == ON_LAST);
  assign off_done = (cnt_reg == OFF_LAST);

  assign lamp  = is_on;
  assign start = START_EN & ~play & press;
  assign hit   = play & is_on & press;
  // A press on the expiry cycle is a hit, so it suppresses the miss.
  assign miss  = MISS_EN & play & is_on & on_done & ~press;
  assign wrong = WRONG_EN & play & ~is_on & press;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a_reg <= 1'b1;
      sync_b_reg <= 1'b1;
      sync_c_reg <= 1'b1;
      state_reg  <= CH_OFF;
      cnt_reg    <= '0;
    end else begin
      sync_a_reg <= btn_n;
      sync_b_reg <= sync_a_reg;
      sync_c_reg <= sync_b_reg;
      if (!play || restart) begin
        state_reg <= CH_OFF;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          CH_OFF: begin
            if (off_done) begin
              state_reg <= CH_ON;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          default: begin
            if (press || on_done) begin
              state_reg <= CH_OFF;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/whack_game_ctrl.sv
// -----------------------------------------------------------------------------
// whack_game_ctrl
// N-channel reaction-game controller: game FSM, saturating score, round timer
// and one-hot score display. Channel timing lives in whack_channel.
//   clk, reset : system clock, synchronous active-high reset
//   btn_n      : N_CH active-low channel buttons (asynchronous)
//   start_n    : active-low start button (asynchronous)
//   lamp       : N_CH lamp drives, 1 = lit
//   score      : current score (saturating, never wraps)
//   in_game    : high in PLAY
//   game_won   : high in WIN
//   game_over  : high in LOSE
//   led        : one-hot of score mod LED_N
// -----------------------------------------------------------------------------
module whack_game_ctrl
  import whack_pkg::*;
#(
  parameter int                       N_CH       = 4,
  parameter int                       SCORE_W    = 32,
  parameter int                       WIN_SCORE  = 12,
  parameter logic [N_CH*TIME_W-1:0]   ON_TIME    = {4{32'd50_000_000}},
  parameter logic [N_CH*TIME_W-1:0]   OFF_TIME   = {4{32'd350_000_000}},
  parameter logic [N_CH-1:0]          MISS_PEN   = 4'b0001,
  parameter bit                       WRONG_PEN  = 1'b0,
  parameter int unsigned              TIME_LIMIT = 0,
  parameter int                       LED_N      = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_CH-1:0]    btn_n,
  input  logic               start_n,
  output logic [N_CH-1:0]    lamp,
  output logic [SCORE_W-1:0] score,
  output logic               in_game,
  output logic               game_won,
  output logic               game_over,
  output logic [LED_N-1:0]   led
);

  // Extra 5 bits cover the +/-N_CH per-cycle delta (N_CH <= 16) plus sign.
  localparam int                    ACC_W       = SCORE_W + 5;
  localparam logic [SCORE_W-1:0]    WIN_TH      = SCORE_W'(WIN_SCORE);
  localparam logic [TIME_W-1:0]     LIMIT       = TIME_W'(TIME_LIMIT);
  localparam logic [TIME_W-1:0]     LIMIT_LAST  = LIMIT - 1'b1;
  localparam logic [TIME_W-1:0]     ELAPSED_MAX = '1;
  localparam logic signed [ACC_W-1:0] ACC_ONE   = ACC_W'(1);
  localparam logic [SCORE_W-1:0]    LED_MOD     = SCORE_W'(LED_N);

  game_state_t              state_reg;
  logic [SCORE_W-1:0]       score_reg;
  logic [SCORE_W-1:0]       score_next;
  logic [TIME_W-1:0]        elapsed_reg;
  logic                     in_game_reg;
  logic                     game_won_reg;
  logic                     game_over_reg;
  logic                     start_a_reg;
  logic                     start_b_reg;
  logic                     start_c_reg;
  logic                     start_press;
  logic [N_CH-1:0]          ch_start;
  logic [N_CH-1:0]          hit;
  logic [N_CH-1:0]          miss;
  logic [N_CH-1:0]          wrong;
  logic                     playing;
  logic                     begin_game;
  logic                     win_fire;
  logic                     lose_fire;
  logic                     chan_clear;
  logic signed [ACC_W-1:0]  acc;
  logic [SCORE_W-1:0]       led_idx;

  // Only channel 0 doubles as a start button.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    whack_channel #(
      .ON_TIME  (ON_TIME[gi*TIME_W +: TIME_W]),
      .OFF_TIME (OFF_TIME[gi*TIME_W +: TIME_W]),
      .MISS_EN  (MISS_PEN[gi]),
      .WRONG_EN (WRONG_PEN),
      .START_EN (gi == 0)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .btn_n   (btn_n[gi]),
      .play    (playing),
      .restart (chan_clear),
      .lamp    (lamp[gi]),
      .start   (ch_start[gi]),
      .hit     (hit[gi]),
      .miss    (miss[gi]),
      .wrong   (wrong[gi])
    );
  end

  assign playing     = (state_reg == PLAY);
  assign start_press = start_c_reg & ~start_b_reg;
  assign begin_game  = !playing && (start_press || (|ch_start));

  always_comb begin
    acc = $signed({5'b0, score_reg});
    for (int i = 0; i < N_CH; i++) begin
      if (hit[i])   acc = acc + ACC_ONE;
      if (miss[i])  acc = acc - ACC_ONE;
      if (wrong[i]) acc = acc - ACC_ONE;
    end
    score_next = SCORE_W'(sat_clamp({{(64-ACC_W){acc[ACC_W-1]}}, acc}, SCORE_W));
  end

  // WIN outranks the time limit when both land on the same edge.
  assign win_fire   = playing && (score_next >= WIN_TH);
  assign lose_fire  = playing && !win_fire && (LIMIT != '0) && (elapsed_reg == LIMIT_LAST);
  assign chan_clear = win_fire | lose_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      score_reg     <= '0;
      elapsed_reg   <= '0;
      in_game_reg   <= 1'b0;
      game_won_reg  <= 1'b0;
      game_over_reg <= 1'b0;
      start_a_reg   <= 1'b1;
      start_b_reg   <= 1'b1;
      start_c_reg   <= 1'b1;
    end else begin
      start_a_reg <= start_n;
      start_b_reg <= start_a_reg;
      start_c_reg <= start_b_reg;
      case (state_reg)
        PLAY: begin
          score_reg <= score_next;
          if (elapsed_reg != ELAPSED_MAX) begin
            elapsed_reg <= elapsed_reg + 1'b1;
          end
          if (win_fire) begin
            state_reg    <= WIN;
            in_game_reg  <= 1'b0;
            game_won_reg <= 1'b1;
          end else if (lose_fire) begin
            state_reg     <= LOSE;
            in_game_reg   <= 1'b0;
            game_over_reg <= 1'b1;
          end
        end
        default: begin
          if (begin_game) begin
            state_reg     <= PLAY;
            score_reg     <= '0;
            elapsed_reg   <= '0;
            in_game_reg   <= 1'b1;
            game_won_reg  <= 1'b0;
            game_over_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    led_idx = score_reg % LED_MOD;
    led     = '0;
    for (int i = 0; i < LED_N; i++) begin
      if (led_idx == SCORE_W'(i)) led[i] = 1'b1;
    end
  end

  assign score     = score_reg;
  assign in_game   = in_game_reg;
  assign game_won  = game_won_reg;
  assign game_over = game_over_reg;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_whack_game_ctrl
// Directed bench for whack_game_ctrl. Two instances share the clock:
//   dut   : no time limit, used for lamp timing, hits, misses and WIN
//   dut_t : TIME_LIMIT = 20, used for LOSE and mid-game reset
// Times in comments are edges counted from the edge where in_game rises.
// -----------------------------------------------------------------------------
module tb_whack_game_ctrl;

  localparam int N_CH  = 2;
  localparam int SW    = 32;
  localparam int LED_N = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_n;
  logic [N_CH-1:0]  btn_n;
  logic [N_CH-1:0]  lamp;
  logic [SW-1:0]    score;
  logic             in_game;
  logic             game_won;
  logic             game_over;
  logic [LED_N-1:0] led;

  logic             reset_t;
  logic             start_t_n;
  logic [N_CH-1:0]  btn_t_n;
  logic [N_CH-1:0]  lamp_t;
  logic [SW-1:0]    score_t;
  logic             in_game_t;
  logic             game_won_t;
  logic             game_over_t;
  logic [LED_N-1:0] led_t;

  int checks = 0;
  int errors = 0;
  int now    = 0;

  always #5 clk = ~clk;

  whack_game_ctrl #(
    .N_CH(N_CH), .SCORE_W(SW), .WIN_SCORE(3),
    .ON_TIME({32'd4, 32'd4}), .OFF_TIME({32'd5, 32'd3}),
    .MISS_PEN(2'b01), .WRONG_PEN(1'b0), .TIME_LIMIT(0), .LED_N(LED_N)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .start_n(start_n),
    .lamp(lamp), .score(score), .in_game(in_game),
    .game_won(game_won), .game_over(game_over), .led(led)
  );

  whack_game_ctrl #(
    .N_CH(N_CH), .SCORE_W(SW), .WIN_SCORE(3),
    .ON_TIME({32'd4, 32'd4}), .OFF_TIME({32'd5, 32'd3}),
    .MISS_PEN(2'b01), .WRONG_PEN(1'b0), .TIME_LIMIT(20), .LED_N(LED_N)
  ) dut_t (
    .clk(clk), .reset(reset_t), .btn_n(btn_t_n), .start_n(start_t_n),
    .lamp(lamp_t), .score(score_t), .in_game(in_game_t),
    .game_won(game_won_t), .game_over(game_over_t), .led(led_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, now, got, exp);
    end else begin
      $display("chk  %s t=%0d value=%0h", tag, now, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic run_to(input int t);
    while (now < t) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d", now);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;  start_n = 1'b1;  btn_n = 2'b11;
    reset_t = 1'b1; start_t_n = 1'b1; btn_t_n = 2'b11;
    repeat (3) tick();
    check("rst_score",     score,     32'd0);
    check("rst_lamp",      lamp,      32'd0);
    check("rst_in_game",   in_game,   32'd0);
    check("rst_game_won",  game_won,  32'd0);
    check("rst_game_over", game_over, 32'd0);
    check("rst_led",       led,       32'h01);

    reset = 1'b0;
    repeat (2) tick();
    check("idle_in_game", in_game, 32'd0);

    // start pulse: effect lands on the third edge after the pin falls
    start_n = 1'b0; tick();
    start_n = 1'b1; tick();
    check("start_lat2", in_game, 32'd0);
    tick();
    check("start_lat3", in_game, 32'd1);
    now = 0;
    check("play_score0", score, 32'd0);
    check("play_lamp0",  lamp,  32'd0);

    run_to(2); check("lamp_dark_t2", lamp, 32'd0);
    run_to(3); check("lamp_on_t3",   lamp, 32'd1);
    run_to(5); check("lamp_both_t5", lamp, 32'd3);
    run_to(6); check("lamp0_t6", lamp[0], 32'd1);
    run_to(7); check("lamp0_off_t7", lamp[0], 32'd0);
    check("miss_sat_t7", score, 32'd0);

    // ch0 relit at 10: press pulse -> hit at 13, then a dark press at 15
    run_to(10); check("lamp0_t10", lamp[0], 32'd1);
    btn_n = 2'b10;
    run_to(11); btn_n = 2'b11;
    run_to(12); check("pre_hit_score", score, 32'd0);
    btn_n = 2'b10;
    run_to(13); btn_n = 2'b11;
    check("hit_score",  score,   32'd1);
    check("hit_lamp0",  lamp[0], 32'd0);
    check("hit_led",    led,     32'h02);
    run_to(15); check("dark_press_score", score, 32'd1);

    // ch1 expires at 18 without penalty
    run_to(17); check("lamp1_t17", lamp[1], 32'd1);
    run_to(18); check("lamp1_off_t18", lamp[1], 32'd0);
    check("ch1_nopen_score", score, 32'd1);

    // ch0 expires unpressed at 20
    run_to(19); check("pre_miss_score", score, 32'd1);
    run_to(20); check("miss_score", score, 32'd0);

    // ch0 lit 23..26; press lands on its expiry cycle
    btn_n = 2'b11;
    run_to(24); btn_n = 2'b10;
    run_to(25); btn_n = 2'b11;
    run_to(26); check("exp_lamp0_t26", lamp[0], 32'd1);
    check("exp_score_t26", score, 32'd0);
    run_to(27); check("exp_hit_score", score, 32'd1);
    check("exp_lamp0_t27", lamp[0], 32'd0);

    // both channels lit at 32; simultaneous hit -> score 3 and WIN at 33
    run_to(30); btn_n = 2'b00;
    run_to(31); btn_n = 2'b11;
    run_to(32); check("both_lamp_t32", lamp, 32'd3);
    check("both_score_t32", score, 32'd1);
    run_to(33); check("win_score",   score,     32'd3);
    check("win_flag",    game_won,  32'd1);
    check("win_in_game", in_game,   32'd0);
    check("win_lamp",    lamp,      32'd0);
    check("win_over",    game_over, 32'd0);
    check("win_led",     led,       32'h08);

    // restart straight from WIN
    run_to(35); start_n = 1'b0;
    run_to(36); start_n = 1'b1;
    run_to(37); check("win_hold", game_won, 32'd1);
    run_to(38); check("restart_in_game", in_game,  32'd1);
    check("restart_score", score,    32'd0);
    check("restart_won",   game_won, 32'd0);
    check("restart_led",   led,      32'h01);

    // time-limited instance
    reset_t = 1'b0; tick();
    start_t_n = 1'b0; tick();
    start_t_n = 1'b1; tick();
    tick();
    check("tl_in_game", in_game_t, 32'd1);
    now = 0;
    run_to(19); check("tl_over_t19", game_over_t, 32'd0);
    check("tl_in_game_t19", in_game_t, 32'd1);
    check("tl_lamp_t19",    lamp_t,    32'd1);
    run_to(20); check("tl_over_t20", game_over_t, 32'd1);
    check("tl_in_game_t20", in_game_t, 32'd0);
    check("tl_lamp_t20",    lamp_t,    32'd0);

    // restart from LOSE, score once, then reset mid-PLAY
    start_t_n = 1'b0; tick();
    start_t_n = 1'b1; tick();
    tick();
    check("tl_restart", in_game_t, 32'd1);
    check("tl_restart_over", game_over_t, 32'd0);
    now = 0;
    run_to(3); check("tl_lamp0_t3", lamp_t[0], 32'd1);
    btn_t_n = 2'b10;
    run_to(4); btn_t_n = 2'b11;
    run_to(6); check("tl_hit_score", score_t, 32'd1);
    reset_t = 1'b1;
    run_to(7);
    check("mid_rst_in_game", in_game_t, 32'd0);
    check("mid_rst_score",   score_t,   32'd0);
    check("mid_rst_lamp",    lamp_t,    32'd0);
    check("mid_rst_led",     led_t,     32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/whack_game_ctrl.md
Name: whack_game_ctrl

Overview:
- Parametrised N-channel reaction-game controller: per-channel lamp timing, synchronised active-low button inputs, saturating score, game FSM (IDLE/PLAY/WIN/LOSE) and a one-hot score display.
- Feeds the VGA/score display path with `in_game`, `score` and the status flags.
- Generalises the fixed 4-button game with:
  - channel count and per-channel timing as parameters;
  - optional miss and wrong-press penalties;
  - an optional round time limit.

Parameters:
- N_CH, 4, number of lamp/button channels (1..16).
- SCORE_W, 32, score width.
- WIN_SCORE, 12, score at or above which the game is won.
- ON_TIME, {4{32'd50_000_000}}, packed N_CH×32, lamp-lit duration per channel, in cycles (each ≥1).
- OFF_TIME, {4{32'd350_000_000}}, packed N_CH×32, lamp-dark duration per channel, in cycles (each ≥1).
- MISS_PEN, 4'b0001, per-channel enable: lit-phase expiry without a hit costs 1 point.
- WRONG_PEN, 0, when 1 a press on a dark lamp costs 1 point.
- TIME_LIMIT, 0, PLAY duration in cycles before LOSE; 0 disables the limit.
- LED_N, 6, width of the one-hot score display (score mod LED_N).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- btn_n  in  N_CH  channel buttons, active-low, asynchronous
- start_n  in  1  start button, active-low, asynchronous
- lamp  out  N_CH  lamp drive, 1 = lit
- score  out  SCORE_W  current score
- in_game  out  1  high in PLAY
- game_won  out  1  high in WIN
- game_over  out  1  high in LOSE
- led  out  LED_N  one-hot of score mod LED_N

Behaviour:
- Reset (synchronous, active-high, takes priority over everything, also mid-game):
  - state IDLE, score 0, lamp 0, all counters 0;
  - synchroniser flops set to 1 (released);
  - in_game, game_won and game_over 0; led = 1 on bit 0.
- Inputs: each of btn_n and start_n passes through a 2-flop synchroniser. A press is a 1→0 transition of the synchronised value, one-cycle pulse. Latency from pin to press pulse is 3 edges.
- States:
  - IDLE/WIN/LOSE → PLAY on a start press or a channel-0 press. On that edge: score ← 0, all channels enter OFF with counters 0, elapsed ← 0, lamp 0.
  - PLAY → WIN when score_next ≥ WIN_SCORE, on the same edge. All lamps go to 0 on that edge.
  - PLAY → LOSE when TIME_LIMIT ≠ 0 and elapsed = TIME_LIMIT−1, on that edge, unless WIN fires on the same edge (WIN has priority). All lamps go to 0.
  - Outside PLAY: channel counters are held at 0, lamps are 0, and presses have no effect except start.
- Channel FSM, active only in PLAY, states OFF/ON:
  - OFF: counter increments each cycle. At counter = OFF_TIME[i]−1 → ON, counter 0. The dark phase lasts exactly OFF_TIME[i] cycles.
  - ON: lamp[i] = 1, counter increments each cycle.
    - Press → OFF, counter 0, hit pulse.
    - Otherwise at counter = ON_TIME[i]−1 → OFF, counter 0, miss pulse if MISS_PEN[i].
  - Press and expiry on the same cycle count as a hit only; no miss.
  - Press while in OFF: no state change; wrong pulse if WRONG_PEN.
- Score arithmetic: delta = Σhit − Σmiss − Σwrong, summed over all channels in one cycle. score_next = clamp(score + delta, 0, 2^SCORE_W−1), computed in a signed SCORE_W+5-bit intermediate. Score never wraps in either direction.
- elapsed: counts PLAY cycles. Saturates and does not wrap.
- Outputs:
  - lamp and the flags are registered.
  - led is decoded combinationally from the score register: led[score mod LED_N] = 1.
- Restart is allowed from WIN or LOSE directly. A start press arriving in PLAY is ignored.

Decomposition:
- Shared package whack_pkg holds:
  - the game_state_t enum (IDLE, PLAY, WIN, LOSE);
  - the ch_state_t enum (CH_OFF, CH_ON);
  - the constant TIME_W = 32;
  - a saturating clamp function.
- Sub-module whack_channel (generated N_CH times) holds:
  - the synchroniser and edge detector;
  - the OFF/ON FSM and phase counter.
  - It takes its ON/OFF times as parameters, plus `play` and `restart` inputs.
  - It outputs lamp, hit, miss and wrong.
- Top level holds the game FSM, the score adder/clamp, elapsed and the led decode.

Test Plan:
- Bench configuration for every scenario unless stated: N_CH=2, ON_TIME={4,4}, OFF_TIME={3,5}, WIN_SCORE=3, MISS_PEN=2'b01, TIME_LIMIT=0, LED_N=6.
- Reset then start press:
  - in_game rises 3 edges after start_n falls;
  - lamp[0] rises exactly 3 cycles after in_game and stays lit 4 cycles;
  - score stays 0 throughout: miss at score 0 saturates.
- Press btn_n[0] while lamp[0] is lit:
  - lamp[0] clears and score becomes 1 three edges after the pin change;
  - led = 6'b000010;
  - a second press while the lamp is dark leaves score at 1.
- Score 1, let channel 0 expire unpressed: score goes to 0 on the expiry edge. Channel 1 expiry with MISS_PEN[1]=0 leaves score unchanged.
- Align a press with the ON-expiry cycle of channel 0: score +1, no decrement.
- Both channels hit on the same cycle at score 1:
  - score becomes 3;
  - state goes to WIN on the same edge: game_won=1, lamps 0, in_game=0;
  - a start press then returns to PLAY with score 0.
- TIME_LIMIT=20, no presses:
  - game_over=1 exactly 20 PLAY cycles after start;
  - asserting reset mid-PLAY forces IDLE, score 0, lamp 0 on the next edge.
